// File: rtl/gstdma_pkg.sv
// Shared definitions for the gstdma floppy/hard-disk DMA controller:
// register bit positions, burst FSM states and FIFO geometry.
package gstdma_pkg;
  localparam int FIFO_WORDS = 16;
  localparam int BURST      = 8;
  localparam int DIR_BIT    = 8;
  localparam int SCREG_BIT  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;
endpackage

// File: rtl/gstdma_fifo.sv
// Word FIFO between the gstmcu burst side and the device byte side.
// Simultaneous push/pop; clear has priority over both.
module gstdma_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk32,
  input  logic         resb,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full && !i_clr;
  assign w_pop   = i_pop && !o_empty && !i_clr;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk32) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk32) begin
    if (!resb || i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      // net change keeps the count exact when both sides move together
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/gstdma.sv
// Device-side end of the gstmcu DMA handshake: mode/sector-count registers,
// RDY burst FSM, and byte packing between the word FIFO and the FDC/ACSI port.
module gstdma
  import gstdma_pkg::*;
#(
  parameter int FIFO_WORDS = gstdma_pkg::FIFO_WORDS,
  parameter int BURST      = gstdma_pkg::BURST
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        RDY_O,
  input  logic        RDY_I,
  input  logic [7:0]  dev_rx_data,
  input  logic        dev_rx_valid,
  output logic        dev_rx_ready,
  output logic [7:0]  dev_tx_data,
  output logic        dev_tx_valid,
  input  logic        dev_tx_ready
);
  localparam int CW = $clog2(FIFO_WORDS) + 1;
  localparam int BW = $clog2(BURST);
  localparam logic [CW-1:0] C_BURST = CW'(BURST);
  localparam logic [CW-1:0] C_FREE  = CW'(FIFO_WORDS - BURST);
  localparam logic [BW-1:0] C_LAST  = BW'(BURST - 1);

  logic [15:0]   r_mode;
  logic [7:0]    r_sc;
  logic          r_armed;
  state_t        r_state;
  logic          r_rdy_o;
  logic [BW-1:0] r_wcnt;
  logic [4:0]    r_bcnt;
  logic          r_rx_ph;
  logic [7:0]    r_rx_hi;
  logic          r_tx_ph;

  logic          w_dir, w_screg, w_wr, w_mode_wr, w_sc_wr, w_dir_flip;
  logic          w_strobe, w_rx_acc, w_tx_acc, w_go;
  logic          w_push, w_pop, w_full, w_empty;
  logic [15:0]   w_wdata, w_head;
  logic [CW-1:0] w_count;

  assign w_dir      = r_mode[DIR_BIT];
  assign w_screg    = r_mode[SCREG_BIT];
  assign w_wr       = clk_en && !FCS_N && !RW && r_armed;
  assign w_mode_wr  = w_wr && A1;
  assign w_sc_wr    = w_wr && !A1 && w_screg;
  assign w_dir_flip = w_mode_wr && (DIN[DIR_BIT] != w_dir);
  assign w_strobe   = clk_en && !RDY_I && (r_state == S_XFER);
  assign w_rx_acc   = dev_rx_valid && dev_rx_ready;
  assign w_tx_acc   = dev_tx_valid && dev_tx_ready;

  assign w_go = (r_sc != 8'd0) && (w_dir ? (w_count <= C_FREE) : (w_count >= C_BURST));

  // DIR=1: gstmcu fills, device drains; DIR=0 the other way round
  assign w_push  = w_dir ? w_strobe : (w_rx_acc && r_rx_ph);
  assign w_pop   = w_dir ? (w_tx_acc && r_tx_ph) : w_strobe;
  assign w_wdata = w_dir ? DIN : {r_rx_hi, dev_rx_data};

  gstdma_fifo #(.DEPTH(FIFO_WORDS), .W(16)) u_fifo (
    .clk32   (clk32),
    .resb    (resb),
    .i_clr   (w_dir_flip),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign RDY_O        = r_rdy_o;
  assign dev_rx_ready = resb && !w_dir && !w_full;
  assign dev_tx_valid = resb && w_dir && !w_empty;
  assign dev_tx_data  = dev_tx_valid ? (r_tx_ph ? w_head[7:0] : w_head[15:8]) : 8'h00;

  always_comb begin
    DOUT = 16'h0000;
    if (!FCS_N && RW) begin
      if (A1)          DOUT = {13'b0, !r_rdy_o, (r_sc != 8'd0), 1'b1};
      else if (w_screg) DOUT = {8'b0, r_sc};
    end else if (!w_dir && (r_state == S_XFER)) begin
      DOUT = w_head;
    end
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      r_mode  <= '0;
      r_sc    <= '0;
      r_armed <= 1'b1;
      r_state <= S_IDLE;
      r_rdy_o <= 1'b1;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_rx_ph <= 1'b0;
      r_rx_hi <= '0;
      r_tx_ph <= 1'b0;
    end else begin
      // one write per FCS_N assertion, however long it is held
      if (FCS_N)     r_armed <= 1'b1;
      else if (w_wr) r_armed <= 1'b0;
      if (w_mode_wr) r_mode <= DIN;

      if (w_dir_flip) begin
        r_state <= S_IDLE;
        r_rdy_o <= 1'b1;
        r_wcnt  <= '0;
        r_bcnt  <= '0;
        r_rx_ph <= 1'b0;
        r_tx_ph <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (clk_en && w_go) r_state <= S_REQ;
          S_REQ: if (clk_en) begin
            r_rdy_o <= 1'b0;
            r_state <= S_XFER;
          end
          S_XFER: if (w_strobe) begin
            if (r_wcnt == C_LAST) begin
              r_wcnt  <= '0;
              r_rdy_o <= 1'b1;
              r_state <= S_IDLE;
              r_bcnt  <= r_bcnt + 5'd1;
              // 32 bursts of 8 words = one 512-byte sector
              if (r_bcnt == 5'h1f && r_sc != 8'd0) r_sc <= r_sc - 8'd1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
        if (w_rx_acc) begin
          r_rx_ph <= !r_rx_ph;
          if (!r_rx_ph) r_rx_hi <= dev_rx_data;
        end
        if (w_tx_acc) r_tx_ph <= !r_tx_ph;
      end

      if (w_sc_wr) r_sc <= DIN[7:0];
    end
  end
endmodule

// File: tb/tb_gstdma.sv
// Self-checking bench for gstdma: register vector table, hand-written corner
// sequences and randomized transfers against a queue-based transfer model.
module tb_gstdma;
  logic        clk32 = 1'b0;
  logic        resb = 1'b0;
  logic        clk_en = 1'b0;
  logic        FCS_N = 1'b1;
  logic        RW = 1'b1;
  logic        A1 = 1'b0;
  logic [15:0] DIN = 16'h0000;
  logic [15:0] DOUT;
  logic        RDY_O;
  logic        RDY_I = 1'b1;
  logic [7:0]  dev_rx_data = 8'h00;
  logic        dev_rx_valid = 1'b0;
  logic        dev_rx_ready;
  logic [7:0]  dev_tx_data;
  logic        dev_tx_valid;
  logic        dev_tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk32 = ~clk32;

  gstdma dut (
    .clk32(clk32), .resb(resb), .clk_en(clk_en), .FCS_N(FCS_N), .RW(RW), .A1(A1),
    .DIN(DIN), .DOUT(DOUT), .RDY_O(RDY_O), .RDY_I(RDY_I),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready),
    .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready)
  );

  typedef struct {
    bit          rd;
    bit          a1;
    logic [15:0] d;
    logic [15:0] exp;
    string       nm;
  } regv_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit en);
    clk_en = en;
    @(posedge clk32);
    #1;
    clk_en = 1'b0;
  endtask

  task automatic bus_cycle();
    step(0); step(0); step(0); step(1);
  endtask

  task automatic wr(input bit a1, input logic [15:0] d);
    FCS_N = 1'b0; RW = 1'b0; A1 = a1; DIN = d;
    bus_cycle();
    FCS_N = 1'b1; RW = 1'b1;
    step(0); step(0);
  endtask

  task automatic rd(input bit a1, output logic [15:0] v);
    FCS_N = 1'b0; RW = 1'b1; A1 = a1;
    #1;
    v = DOUT;
    FCS_N = 1'b1;
    #1;
  endtask

  // Offer bytes continuously with no gstmcu strobes; count how many are taken.
  task automatic fill(output int n);
    n = 0;
    dev_rx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      dev_rx_data = n[7:0];
      #1;
      if (dev_rx_ready) n++;
      step(k % 4 == 3);
    end
    dev_rx_valid = 1'b0;
  endtask

  task automatic no_req(input string nm, input int steps);
    bit low = 1'b0;
    for (int k = 0; k < steps; k++) begin
      step(k % 4 == 3);
      if (!RDY_O) low = 1'b1;
    end
    chk(nm, low, 0);
  endtask

  // Device -> memory, one sector: device bytes 0x00..0xFF twice, gstmcu strobes randomly.
  task automatic dev2mem();
    int acc = 0, pops = 0, bstr = 0, bursts = 0;
    logic [7:0]  hi = 8'h00;
    logic [15:0] wq[$];
    logic [15:0] first_w = 16'hxxxx;
    logic [15:0] v;
    wr(1, 16'h0010); wr(0, 16'h0001); wr(1, 16'h0000);
    for (int k = 0; k < 40000 && pops < 256; k++) begin
      bit en, stb, exp_rdy;
      int words;
      en = (k % 4 == 3);
      words = acc / 2 - pops;
      exp_rdy = (words < 16);
      dev_rx_valid = (acc < 512) && ($urandom_range(0, 3) != 0);
      dev_rx_data = acc[7:0];
      stb = en && !RDY_O && ($urandom_range(0, 3) != 0);
      RDY_I = !stb;
      #1;
      chk("d2m_rx_ready", dev_rx_ready, exp_rdy);
      if (stb) begin
        if (wq.size() == 0) chk("d2m_underrun", 0, 1);
        else begin
          v = wq.pop_front();
          if (pops == 0) first_w = DOUT;
          chk("d2m_dout", DOUT, v);
        end
      end
      if (dev_rx_valid && exp_rdy) begin
        if (acc % 2 == 0) hi = dev_rx_data;
        else wq.push_back({hi, dev_rx_data});
        acc++;
      end
      step(en);
      RDY_I = 1'b1;
      if (stb) begin
        pops++; bstr++;
        if (bstr == 8) begin
          chk("d2m_rdy_release", RDY_O, 1);
          bstr = 0; bursts++;
        end
      end
    end
    dev_rx_valid = 1'b0;
    chk("d2m_words", pops, 256);
    chk("d2m_bursts", bursts, 32);
    chk("d2m_first_word", first_w, 16'h0001);
    wr(1, 16'h0010);
    rd(0, v); chk("d2m_sc_zero", v, 16'h0000);
    rd(1, v); chk("d2m_status", v, 16'h0001);
    dev_rx_valid = 1'b1;
    no_req("d2m_no_more_req", 200);
    dev_rx_valid = 1'b0;
  endtask

  // Memory -> device, one sector: gstmcu strobes 0x1234+n, device drains randomly.
  task automatic mem2dev();
    int str = 0, popw = 0, rxb = 0, bstr = 0, bursts = 0;
    logic [7:0]  bq[$];
    logic [7:0]  b;
    logic [15:0] v;
    wr(1, 16'h0110);
    chk("m2d_fifo_cleared", dev_tx_valid, 0);
    wr(0, 16'h0001);
    for (int k = 0; k < 40000 && (str < 256 || bq.size() > 0); k++) begin
      bit en, stb, exp_val;
      en = (k % 4 == 3);
      exp_val = (str - popw) > 0;
      dev_tx_ready = ($urandom_range(0, 2) != 0);
      stb = en && !RDY_O && ($urandom_range(0, 3) != 0);
      RDY_I = !stb;
      DIN = 16'h1234 + str[15:0];
      #1;
      chk("m2d_tx_valid", dev_tx_valid, exp_val);
      if (exp_val && dev_tx_ready) begin
        if (bq.size() == 0) chk("m2d_underrun", 0, 1);
        else begin
          b = bq.pop_front();
          chk("m2d_tx_data", dev_tx_data, b);
        end
        rxb++;
        if (rxb % 2 == 0) popw++;
      end
      if (stb) begin
        bq.push_back(DIN[15:8]);
        bq.push_back(DIN[7:0]);
      end
      step(en);
      RDY_I = 1'b1;
      if (stb) begin
        str++; bstr++;
        if (bstr == 8) begin
          chk("m2d_rdy_release", RDY_O, 1);
          bstr = 0; bursts++;
        end
      end
    end
    chk("m2d_words", str, 256);
    chk("m2d_bytes", rxb, 512);
    chk("m2d_bursts", bursts, 32);
    rd(0, v); chk("m2d_sc_zero", v, 16'h0000);
    dev_tx_ready = 1'b1;
    no_req("m2d_no_more_req", 200);
    dev_tx_ready = 1'b0;
  endtask

  initial begin
    regv_t tbl[12];
    logic [15:0] v;
    int n, cnt;

    tbl = '{
      '{0, 1, 16'h0010, 16'h0000, "mode_wr"},
      '{1, 1, 16'h0000, 16'h0001, "stat_sc0"},
      '{0, 0, 16'h00A5, 16'h0000, "sc_wr"},
      '{1, 0, 16'h0000, 16'h00A5, "sc_rd"},
      '{1, 1, 16'h0000, 16'h0003, "stat_scnz"},
      '{0, 1, 16'h0000, 16'h0000, "mode_clr"},
      '{1, 0, 16'h0000, 16'h0000, "sc_hidden"},
      '{0, 0, 16'h0033, 16'h0000, "sc_wr_ignored"},
      '{0, 1, 16'h0010, 16'h0000, "mode_wr2"},
      '{1, 0, 16'h0000, 16'h00A5, "sc_unchanged"},
      '{0, 0, 16'h0000, 16'h0000, "sc_wr0"},
      '{1, 1, 16'h0000, 16'h0001, "stat_final"}
    };

    // reset values
    repeat (4) step(0);
    chk("rst_rdy_o", RDY_O, 1);
    chk("rst_dout", DOUT, 0);
    chk("rst_rx_ready", dev_rx_ready, 0);
    chk("rst_tx_valid", dev_tx_valid, 0);
    chk("rst_tx_data", dev_tx_data, 0);
    resb = 1'b1;
    step(0);
    rd(1, v); chk("rst_status", v, 16'h0001);

    // register vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rd) begin
        rd(tbl[i].a1, v);
        chk(tbl[i].nm, v, tbl[i].exp);
      end else begin
        wr(tbl[i].a1, tbl[i].d);
      end
    end

    // long write access: only the first clk_en cycle counts
    FCS_N = 1'b0; RW = 1'b0; A1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DIN = 16'h0011 * 16'(i + 1);
      bus_cycle();
    end
    FCS_N = 1'b1; RW = 1'b1;
    step(0);
    rd(0, v); chk("hold_first_only", v, 16'h0011);
    wr(0, 16'h0000);

    // DIR toggle after 2 full bursts plus 3 strobes
    wr(1, 16'h0110);
    wr(0, 16'h0001);
    dev_tx_ready = 1'b1;
    n = 0;
    cnt = 0;
    while (n < 19 && cnt < 2000) begin
      step(0); step(0); step(0);
      DIN = 16'hBE00 + 16'(n);
      if (!RDY_O) begin
        RDY_I = 1'b0;
        n++;
      end
      step(1);
      RDY_I = 1'b1;
      cnt++;
    end
    dev_tx_ready = 1'b0;
    chk("tog_strobes", n, 19);
    FCS_N = 1'b0; RW = 1'b0; A1 = 1'b1; DIN = 16'h0010;
    step(0); step(0); step(0);
    chk("tog_mid_burst", RDY_O, 0);
    step(1);
    chk("tog_rdy_release", RDY_O, 1);
    chk("tog_tx_empty", dev_tx_valid, 0);
    FCS_N = 1'b1; RW = 1'b1;
    step(0);

    // a stale burst counter would end the sector early and starve this run
    dev2mem();
    mem2dev();

    // backpressure: no strobes, device keeps offering
    wr(1, 16'h0010);
    wr(0, 16'h0001);
    fill(n);
    chk("bp_bytes", n, 32);
    chk("bp_rx_ready_low", dev_rx_ready, 0);
    chk("bp_req", RDY_O, 0);

    // reset during an outstanding request
    resb = 1'b0;
    step(0);
    chk("rst2_rdy_o", RDY_O, 1);
    chk("rst2_rx_ready", dev_rx_ready, 0);
    step(0); step(0); step(0);
    chk("rst2_tx_valid", dev_tx_valid, 0);
    chk("rst2_dout", DOUT, 0);
    resb = 1'b1;
    step(0);
    rd(1, v); chk("rst2_status", v, 16'h0001);
    fill(n);
    chk("rst2_fifo_empty", n, 32);
    chk("rst2_no_req", RDY_O, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gstdma.md
# gstdma

Atari ST/STE floppy/hard-disk DMA controller: the device-side end of the gstmcu DMA handshake (FCS_N register access, RDY request/strobe). It owns the mode register, the sector counter and a 16-word FIFO, and requests 8-word bursts from gstmcu. gstmcu keeps the DMA address counter and performs the RAM cycles. A byte-stream port on the other side connects to the FDC/ACSI model.

## Interface

Parameters:
- FIFO_WORDS, 16: FIFO depth in words. Fixed; power of two.
- BURST, 8: number of words per RDY burst.

Ports:
- clk32  in  1  system clock
- resb  in  1  synchronous reset, active-low
- clk_en  in  1  8 MHz enable (MHZ8_EN1); all bus sampling happens on clk_en cycles
- FCS_N  in  1  register chip select from gstmcu, active-low
- RW  in  1  CPU read(1)/write(0)
- A1  in  1  0 = data/sector-count register (FF8604), 1 = mode/status register (FF8606)
- DIN  in  16  register-write data and memory→device burst data
- DOUT  out  16  register-read data and device→memory burst data
- RDY_O  out  1  burst request to gstmcu, active-low
- RDY_I  in  1  per-word transfer strobe from gstmcu, active-low
- dev_rx_data  in  8  byte from device
- dev_rx_valid  in  1  device byte available
- dev_rx_ready  out  1  FIFO accepts byte
- dev_tx_data  out  8  byte to device
- dev_tx_valid  out  1  byte available to device
- dev_tx_ready  in  1  device accepts byte

## Operation

- Registers are written on the first clk_en cycle with FCS_N=0 and RW=0 of each access; the block rearms when FCS_N returns high.
  - A1=1 write: mode[15:0] is loaded. If bit 8 (DIR: 1 = memory→device) toggles, the FIFO is cleared, the byte/burst counters are cleared and any burst is aborted.
  - A1=0 write with mode[4]=1: sector_count[7:0] is loaded from DIN[7:0].
  - A1=0 write with mode[4]=0: the write is ignored.
- Reads (FCS_N=0, RW=1):
  - A1=1 returns {13'b0, drq, sc_nz, 1'b1}.
  - A1=0 with mode[4]=1 returns {8'b0, sector_count}.
  - Otherwise the read returns 0.
- Burst FSM states: IDLE → REQ → XFER → IDLE.
  - IDLE→REQ when sector_count≠0 and one of:
    - DIR=0 and FIFO holds ≥BURST words;
    - DIR=1 and FIFO has ≥BURST free words.
  - REQ drives RDY_O=0. Each clk_en cycle with RDY_I=0 is one word transfer:
    - DIR=0: DOUT = FIFO head, which is popped.
    - DIR=1: DIN is pushed.
  - On the BURST-th strobe the FSM goes to IDLE, and RDY_O=1 from the next cycle.
  - burst_cnt[4:0] counts bursts. On its wrap (32 bursts = 512 bytes) sector_count decrements, saturating at 0.
- Device side, DIR=0:
  - dev_rx_ready=1 when the FIFO is not full.
  - Bytes are packed high byte first; a word is pushed on the low byte.
- Device side, DIR=1:
  - dev_tx_valid=1 when the FIFO is not empty.
  - The high byte of the head word is sent first; the word is popped after the low byte is accepted.
  - The device side ignores sector_count.
- drq = RDY_O asserted. sc_nz = (sector_count≠0).
- When a burst strobe and a device-side push/pop land in the same cycle, the FIFO count is updated by the net change; it never over- or underflows.

## Timing

- Reset values: RDY_O=1, DOUT=0, dev_rx_ready=0, dev_tx_valid=0, dev_tx_data=0, mode=0, sector_count=0, FIFO empty, FSM=IDLE.
- Asserting resb=0 mid-burst releases RDY_O on the next clk32 edge.
- The REQ condition is evaluated on a clk_en cycle; RDY_O falls on the following clk_en cycle.
- DOUT presents the head word combinationally from the FIFO. It is stable while RDY_I=0 and advances after the pop.
- Device handshakes operate on every clk32; a transfer occurs when valid&ready.
- Register read data is combinational on A1/mode.

## Structure

- The shared package `gstdma_pkg` holds:
  - register bit positions (DIR=8, SCREG=4);
  - the FSM state enum;
  - FIFO_WORDS and BURST.
- One sub-module, `gstdma_fifo`: a 16×16 synchronous FIFO with simultaneous push/pop and count output. Byte packing and unpacking stay in gstdma.

## Test plan

- **Reset:** resb low for 4 cycles mid-REQ → RDY_O=1, status read = 0x0001, FIFO empty.
- **Device→memory:** mode=0x0010, write sector_count=1, mode=0x0000, then feed 512 bytes 0x00..0xFF,0x00..0xFF.
  - Expected: 32 bursts of 8 strobes.
  - First word read is 0x0001.
  - sector_count=0 after the last burst, and no further RDY_O.
- **Memory→device:** set DIR=1 (FIFO clears), sector_count=1, strobe in words 0x1234…; device ready continuously.
  - Expected: dev_tx bytes 0x12,0x34,… in order.
  - After 32 bursts, no more requests.
- **Backpressure:** DIR=0, dev_rx_valid held high, no RDY_I strobes → dev_rx_ready drops after exactly 32 bytes; RDY_O=0.
- **DIR toggle mid-burst:** after 3 strobes, write mode with DIR flipped → RDY_O=1 next cycle, FIFO count 0, burst_cnt 0.
- **Register access:** an FCS_N=0 write held for 5 clk_en cycles with changing DIN → only the first value is latched. A sector_count write with mode[4]=0 → count is unchanged.
